// File: rtl/dec_sel_sequencer.sv
// Select sequencer for the 2-to-4 decoder: steps {a,b} through all four codes with a programmable dwell.
// Define SEL_GRAY_EN for Gray sweep order (00,01,11,10); default is binary order.
module dec_sel_sequencer #(
  parameter int DW_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            mode_cont_i,
  input  logic [DW_W-1:0] dwell_i,
  output logic            a_o,
  output logic            b_o,
  output logic            sel_valid_o,
  output logic            step_pulse_o,
  output logic            done_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

`ifdef SEL_GRAY_EN
  localparam logic [1:0] LAST_CODE = 2'b10;
  function automatic logic [1:0] next_code(input logic [1:0] s);
    case (s)
      2'b00:   next_code = 2'b01;
      2'b01:   next_code = 2'b11;
      2'b11:   next_code = 2'b10;
      default: next_code = 2'b00;
    endcase
  endfunction
`else
  localparam logic [1:0] LAST_CODE = 2'b11;
  function automatic logic [1:0] next_code(input logic [1:0] s);
    next_code = s + 2'b01;
  endfunction
`endif

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [DW_W-1:0] cnt_q, cnt_d;
  logic [DW_W-1:0] rld_q, rld_d;   // dw_lat-1, reloaded on every code change
  logic            cont_q, cont_d;
  logic            valid_q, valid_d;
  logic            step_q, step_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      rld_q   <= '0;
      cont_q  <= 1'b0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      cont_q  <= cont_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // stop has priority over start and over the dwell-expiry step
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    cont_d  = cont_q;
    if (stop_i) begin
      state_d = S_IDLE;
      sel_d   = 2'b00;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          state_d = S_RUN;
          sel_d   = 2'b00;
          rld_d   = (dwell_i == '0) ? '0 : dwell_i - 1'b1;
          cnt_d   = (dwell_i == '0) ? '0 : dwell_i - 1'b1;
          cont_d  = mode_cont_i;
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (sel_q != LAST_CODE || cont_q) begin
            sel_d = next_code(sel_q);
            cnt_d = rld_q;
          end else begin
            state_d = S_DONE;
            sel_d   = 2'b00;
          end
        end
        default: begin
          state_d = S_IDLE;
          sel_d   = 2'b00;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in flops alongside it
  always_comb begin
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    step_d  = (state_q == S_RUN) && (state_d == S_RUN) && (sel_d != sel_q);
  end

  assign a_o          = sel_q[1];
  assign b_o          = sel_q[0];
  assign sel_valid_o  = valid_q;
  assign step_pulse_o = step_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Bench for dec_sel_sequencer: vector table, directed corner sequences, and random traffic vs a
// timeline model (elapsed cycles since start decide code, step and done).
module tb_dec_sel_sequencer;
  localparam int DW_W = 16;

  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, mode_cont = 1'b0;
  logic [DW_W-1:0] dwell = '0;
  logic a, b, sel_valid, step_pulse, done, busy;
  int n_cmp = 0, n_bad = 0;

  dec_sel_sequencer #(.DW_W(DW_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .mode_cont_i(mode_cont),
    .dwell_i(dwell), .a_o(a), .b_o(b), .sel_valid_o(sel_valid), .step_pulse_o(step_pulse),
    .done_o(done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  logic [1:0] seq [4];

  // Model: a sweep is a timeline t = cycles since sel_valid rose
  bit m_act, m_cont;
  int m_t, m_dw;

  function automatic logic [5:0] m_out();
    logic [1:0] c;
    if (!m_act) return 6'b0;
    if (m_cont || m_t < 4 * m_dw) begin
      c = seq[(m_t / m_dw) % 4];
      return {c, 1'b1, (m_t > 0 && m_t % m_dw == 0), 1'b0, 1'b1};
    end
    return 6'b000011;
  endfunction

  task automatic m_step(input bit st, input bit sp, input bit mc, input int dw);
    if (!m_act) begin
      if (st && !sp) begin
        m_act = 1; m_t = 0; m_dw = (dw == 0) ? 1 : dw; m_cont = mc;
      end
    end else if (sp) m_act = 0;
    else begin
      m_t++;
      if (!m_cont && m_t > 4 * m_dw) m_act = 0;
    end
  endtask

  task automatic check(input string nm, input logic [5:0] exp);
    logic [5:0] act;
    act = {a, b, sel_valid, step_pulse, done, busy};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t {a,b,valid,step,done,busy} got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit st, input bit sp, input bit mc, input int dw, input string nm);
    start = st; stop = sp; mode_cont = mc; dwell = dw[DW_W-1:0];
    @(posedge clk);
    m_step(st, sp, mc, dw);
    @(negedge clk);
    check(nm, m_out());
  endtask

  typedef struct {
    bit st, sp, mc; int dw;
    bit [1:0] ci; bit v, s, d, bz;
  } vec_t;

  vec_t tbl [17];
  int steps, done_at;

  initial begin
`ifdef SEL_GRAY_EN
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
    seq = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif
    m_act = 0; m_t = 0; m_dw = 1; m_cont = 0;

    //          st sp mc dw  ci v  s  d  bz
    tbl[0]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0};  // start+stop in IDLE -> stay IDLE
    tbl[1]  = '{1, 0, 0, 0,  0, 1, 0, 0, 1};  // dwell 0 acts as 1
    tbl[2]  = '{0, 0, 0, 0,  1, 1, 1, 0, 1};
    tbl[3]  = '{1, 0, 1, 5,  2, 1, 1, 0, 1};  // start while RUN ignored
    tbl[4]  = '{0, 0, 0, 0,  3, 1, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 0,  0, 0, 0, 1, 1};  // DONE
    tbl[6]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 1,  0, 1, 0, 0, 1};  // continuous, dwell 1
    tbl[8]  = '{0, 0, 1, 1,  1, 1, 1, 0, 1};
    tbl[9]  = '{0, 0, 1, 1,  2, 1, 1, 0, 1};
    tbl[10] = '{0, 0, 1, 1,  3, 1, 1, 0, 1};
    tbl[11] = '{0, 0, 1, 1,  0, 1, 1, 0, 1};  // wrap with step, no done
    tbl[12] = '{0, 1, 1, 1,  0, 0, 0, 0, 0};  // stop beats step
    tbl[13] = '{1, 0, 0, 2,  0, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 2,  0, 1, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 2,  1, 1, 1, 0, 1};
    tbl[16] = '{0, 1, 0, 2,  0, 0, 0, 0, 0};

    // reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset", 6'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 6'b0);

    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; mode_cont = tbl[i].mc; dwell = tbl[i].dw[DW_W-1:0];
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {tbl[i].v ? seq[tbl[i].ci] : 2'b00, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].bz});
    end

    // one-shot dwell=200: 3 steps, done 800 cycles after sel_valid rises
    steps = 0; done_at = -1;
    cyc(1, 0, 0, 200, "t2_start");
    for (int i = 1; i <= 805; i++) begin
      cyc(0, 0, 0, 0, "t2_run");
      if (step_pulse) steps++;
      if (done && done_at < 0) done_at = i;
    end
    n_cmp++;
    if (steps != 3) begin n_bad++; $display("FAIL t2_steps got %0d expected 3", steps); end
    n_cmp++;
    if (done_at != 800) begin n_bad++; $display("FAIL t2_done_at got %0d expected 800", done_at); end

    // continuous dwell=3 until stop
    cyc(1, 0, 1, 3, "t3_start");
    repeat (40) cyc(0, 0, 0, 0, "t3_run");
    cyc(0, 1, 0, 0, "t3_stop");

    // start during RUN with other dwell/mode is ignored
    cyc(1, 0, 0, 5, "t5_start");
    repeat (3) cyc(1, 0, 1, 9, "t5_restart");
    repeat (20) cyc(0, 0, 0, 0, "t5_run");

    // async reset mid-sweep
    cyc(1, 0, 1, 4, "t1_start");
    repeat (6) cyc(0, 0, 0, 0, "t1_run");
    #2 rst_n = 1'b0;
    #1 check("t1_async_reset", 6'b0);
    m_act = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, "t1_idle");

    // max dwell: first step at exactly 65535 cycles, no wraparound
    cyc(1, 0, 0, 65535, "max_start");
    repeat (65536) cyc(0, 0, 0, 0, "max_run");
    cyc(0, 1, 0, 0, "max_stop");

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 5)), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
